// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync, data enable,
// line/frame strobes and a frame counter, all registered together.
module vga_timing_gen #(
    parameter int CNT_W    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    output logic [CNT_W-1:0]   h_cnt,
    output logic [CNT_W-1:0]   v_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_RANGE = 2 ** CNT_W;

    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Counters must be wide enough to hold the whole raster.
    generate
        if (H_TOTAL > CNT_RANGE) begin : g_h_too_wide
            $error("H_TOTAL does not fit in CNT_W bits");
        end
        if (V_TOTAL > CNT_RANGE) begin : g_v_too_wide
            $error("V_TOTAL does not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               de_q, de_d;
    logic               ls_q, ls_d;
    logic               fs_q, fs_d;
    logic [FRAME_W-1:0] fc_q, fc_d;

    function automatic logic in_win(
        input logic [CNT_W-1:0] x,
        input int               lo,
        input int               hi
    );
        int xv;
        xv = int'(x);
        return (xv >= lo) && (xv < hi);
    endfunction

    // Next raster position and decodes of that position, so that
    // counters and decodes land on the same edge with no skew.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        fc_d = fc_q;
        if (cen) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
            hs_d = in_win(h_d, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
            vs_d = in_win(v_d, VS_LO, VS_HI) ? VS_POL : ~VS_POL;
            de_d = in_win(h_d, 0, H_ACTIVE)
                && in_win(v_d, 0, V_ACTIVE);
            ls_d = (h_d == '0);
            fs_d = (h_d == '0) && (v_d == '0);
            if (fs_d) begin
                fc_d = fc_q + FRAME_W'(1);
            end
        end
    end

    // Raster state; reset parks at the last pixel so the first
    // enabled edge lands on (0,0) with a frame strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q  <= H_LAST;
            v_q  <= V_LAST;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fc_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;

endmodule
